// File: rtl/key_event_pkg.sv
// Shared types for the keypad event queue: key/code sizing, the queued
// event layout and the autorepeat tracker states.
package key_event_pkg;

    localparam int NKEYS  = 16;
    localparam int CODE_W = $clog2(NKEYS);

    // One queued event. Packed as {rpt, code}, which is the same layout the
    // queue stores in its FIFO entries.
    typedef struct packed {
        logic              rpt;
        logic [CODE_W-1:0] code;
    } key_event_t;

    // Autorepeat tracker: idle, waiting out the initial hold delay, or
    // ticking at the repeat rate.
    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RATE  = 2'd2
    } rep_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is ignored and the caller decides what that means.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = count_q;

    // Head entry falls through; reads as zero while nothing is queued.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible past count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns the keypad scanner's debounced level vector into discrete key-code
// events (fresh presses plus autorepeats) and queues them for the control
// FSMs behind a valid/ready handshake.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int NKEYS        = key_event_pkg::NKEYS,
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NKEYS-1:0]           key,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [$clog2(NKEYS)-1:0]   ev_code,
    output logic                       ev_repeat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int CODE_BITS = $clog2(NKEYS);
    localparam int EV_W      = CODE_BITS + 1;
    localparam int CNT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

    // Edge detection and press scheduling
    logic [NKEYS-1:0]     key_q, key_d;
    logic [NKEYS-1:0]     pending_q, pending_d;
    logic [NKEYS-1:0]     rise;
    logic [NKEYS-1:0]     grant_onehot;
    logic [CODE_BITS-1:0] grant_code;
    logic                 grant_valid;

    // Autorepeat tracker
    rep_state_e           state_q, state_d;
    logic [CODE_BITS-1:0] tracked_q, tracked_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rep_req_q, rep_req_d;
    logic                 rep_tick;
    logic                 key_held;
    logic                 rep_push;

    // Queue interface
    logic                 push;
    logic [EV_W-1:0]      push_data;
    logic [EV_W-1:0]      head_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_fire;
    logic                 drop;
    logic                 overflow_q, overflow_d;

    assign rise  = key & ~key_q;
    assign key_d = key;

    // Grant the lowest-indexed pending press; the downward scan lets the
    // lowest set bit be the last one written.
    always_comb begin
        grant_valid  = 1'b0;
        grant_code   = '0;
        grant_onehot = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_valid     = 1'b1;
                grant_code      = CODE_BITS'(i);
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Pending presses stay latched until granted, so short taps survive.
    assign pending_d = (pending_q | rise) & ~grant_onehot;

    assign key_held = key[tracked_q];

    // An outstanding repeat goes out only when no press wants the slot and
    // its key is still down; a release in the same cycle drops it.
    assign rep_push = rep_req_q & ~grant_valid & key_held;

    // Repeat tracker next-state: count out the hold delay, then tick at the
    // repeat rate; release idles it and a new press takes over tracking.
    always_comb begin
        state_d   = state_q;
        tracked_d = tracked_q;
        cnt_d     = cnt_q;
        rep_tick  = 1'b0;
        rep_req_d = rep_req_q;

        case (state_q)
            REP_DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    rep_tick = 1'b1;
                    cnt_d    = '0;
                    state_d  = REP_RATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REP_RATE: begin
                if (cnt_q == RATE_LAST) begin
                    rep_tick = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        if (rep_push) begin
            rep_req_d = 1'b0;
        end
        if (rep_tick) begin
            rep_req_d = 1'b1;
        end

        if (state_q != REP_IDLE && !key_held) begin
            state_d   = REP_IDLE;
            cnt_d     = '0;
            rep_req_d = 1'b0;
        end

        // A repeat owed to the previously tracked key is abandoned when a
        // newer press takes over, since it would carry the wrong code.
        if (grant_valid && REPEAT_DELAY != 0) begin
            state_d   = REP_DELAY;
            tracked_d = grant_code;
            cnt_d     = '0;
            rep_req_d = 1'b0;
        end
    end

    // Enqueue arbitration: presses beat repeats, one event per cycle.
    assign push      = grant_valid | rep_push;
    assign push_data = grant_valid ? {1'b0, grant_code} : {1'b1, tracked_q};

    assign pop_fire  = ev_ready & ~fifo_empty;
    assign drop      = push & fifo_full & ~pop_fire;

    // A drop in the same cycle as a clear leaves the flag set.
    assign overflow_d = (overflow_q & ~clr_ovf) | drop;

    // All control state registers; reset flushes pending presses and the tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '0;
            pending_q  <= '0;
            state_q    <= REP_IDLE;
            tracked_q  <= '0;
            cnt_q      <= '0;
            rep_req_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            key_q      <= key_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            tracked_q  <= tracked_d;
            cnt_q      <= cnt_d;
            rep_req_q  <= rep_req_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (ev_ready),
        .rdata (head_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid  = ~fifo_empty;
    assign ev_repeat = head_data[CODE_BITS];
    assign ev_code   = head_data[CODE_BITS-1:0];
    assign overflow  = overflow_q;

endmodule
